// File: rtl/adc_align_pkg.sv
// Shared types and defaults for the ADC lane aligner: lane FSM state encoding,
// default training parameters and the error-counter width.
package adc_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_TAP    = 3'd4,
        ST_WAIT   = 3'd5,
        ST_LOCKED = 3'd6,
        ST_FAIL   = 3'd7
    } lane_state_e;

    localparam int         ERR_CNT_W           = 16;
    localparam logic [5:0] DEF_LANE_PATTERN    = 6'b111000;
    localparam int         DEF_MATCH_COUNT     = 16;
    localparam int         DEF_SLIP_WAIT       = 4;
    localparam int         DEF_MAX_TAPS        = 32;

    // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/adc_lane_align_fsm.sv
// Per-lane alignment FSM: walks bitslip/tap candidates until the lane word matches
// the training pattern MATCH_COUNT times in a row. Error counter under ADC_ALIGN_ERRCNT_EN.
module adc_lane_align_fsm
    import adc_align_pkg::*;
#(
    parameter int                   LANE_BITS    = 6,
    parameter logic [LANE_BITS-1:0] LANE_PATTERN = DEF_LANE_PATTERN,
    parameter int                   MATCH_COUNT  = DEF_MATCH_COUNT,
    parameter int                   SLIP_WAIT    = DEF_SLIP_WAIT,
    parameter int                   MAX_TAPS     = DEF_MAX_TAPS
) (
    input  logic                 lclk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LANE_BITS-1:0] lane_word,
    output logic                 bitslip,
    output logic                 delay_rst,
    output logic                 delay_ce,
    output logic                 delay_inc,
    output logic                 lane_locked,
    output logic                 lane_fail,
    output logic                 lane_busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int MATCH_W = cnt_w(MATCH_COUNT);
    localparam int SLIP_W  = cnt_w(LANE_BITS - 1);
    localparam int TAP_W   = cnt_w(MAX_TAPS - 1);
    localparam int WAIT_W  = cnt_w(SLIP_WAIT - 1);

    lane_state_e         state_q, state_d;
    logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
    logic [SLIP_W-1:0]   slip_cnt_q, slip_cnt_d;
    logic [TAP_W-1:0]    tap_cnt_q, tap_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                word_match;

    assign word_match = (lane_word == LANE_PATTERN);

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        tap_cnt_d   = tap_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            ST_INIT: begin
                match_cnt_d = '0;
                slip_cnt_d  = '0;
                tap_cnt_d   = '0;
                wait_cnt_d  = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = ST_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (word_match) begin
                    match_cnt_d = match_cnt_q + 1'b1;
                    if (match_cnt_q == MATCH_W'(MATCH_COUNT - 1)) begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    // Slips are exhausted at each tap before stepping the delay line.
                    match_cnt_d = '0;
                    if (slip_cnt_q < SLIP_W'(LANE_BITS - 1)) begin
                        state_d = ST_SLIP;
                    end else if (tap_cnt_q < TAP_W'(MAX_TAPS - 1)) begin
                        state_d = ST_TAP;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_SLIP: begin
                slip_cnt_d = slip_cnt_q + 1'b1;
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_TAP: begin
                tap_cnt_d  = tap_cnt_q + 1'b1;
                slip_cnt_d = '0;
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            default: ;
        endcase
        // A restart overrides everything; a pulse state already active still lasts its one cycle.
        if (start) begin
            state_d = ST_INIT;
        end
    end

    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            match_cnt_q <= '0;
            slip_cnt_q  <= '0;
            tap_cnt_q   <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
            tap_cnt_q   <= tap_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign bitslip     = (state_q == ST_SLIP);
    assign delay_rst   = (state_q == ST_INIT);
    assign delay_ce    = (state_q == ST_TAP);
    assign delay_inc   = (state_q == ST_TAP);
    assign lane_locked = (state_q == ST_LOCKED);
    assign lane_fail   = (state_q == ST_FAIL);
    assign lane_busy   = (state_q == ST_INIT) || (state_q == ST_CHECK) || (state_q == ST_SLIP) ||
                         (state_q == ST_TAP)  || (state_q == ST_WAIT);

`ifdef ADC_ALIGN_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (start) begin
            err_cnt_d = '0;
        end else if ((state_q == ST_LOCKED) && !word_match && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: rtl/adc_lane_aligner.sv
// N-lane ADC word aligner: stages the SERDES words, runs one alignment FSM per lane
// and assembles the sample word. Optional post-lock error counters: ADC_ALIGN_ERRCNT_EN.
module adc_lane_aligner
    import adc_align_pkg::*;
#(
    parameter int                   N_LANES      = 2,
    parameter int                   LANE_BITS    = 6,
    parameter logic [LANE_BITS-1:0] LANE_PATTERN = DEF_LANE_PATTERN,
    parameter int                   MATCH_COUNT  = DEF_MATCH_COUNT,
    parameter int                   SLIP_WAIT    = DEF_SLIP_WAIT,
    parameter int                   MAX_TAPS     = DEF_MAX_TAPS
) (
    input  logic                           lclk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [N_LANES*LANE_BITS-1:0]   lane_words,
    output logic [N_LANES-1:0]             bitslip,
    output logic [N_LANES-1:0]             delay_rst,
    output logic [N_LANES-1:0]             delay_ce,
    output logic [N_LANES-1:0]             delay_inc,
    output logic [N_LANES-1:0]             lane_locked,
    output logic [N_LANES-1:0]             lane_fail,
    output logic                           all_locked,
    output logic                           busy,
    output logic [N_LANES*LANE_BITS-1:0]   adc_bits,
    output logic [ERR_CNT_W*N_LANES-1:0]   err_cnt
);

    logic [N_LANES*LANE_BITS-1:0] stage1_q, stage1_d;
    logic [N_LANES*LANE_BITS-1:0] stage2_q, stage2_d;
    logic [N_LANES-1:0]           lane_busy;

    // Stage 1 feeds the pattern compare; stage 2 is the fixed-latency data output.
    always_comb begin
        stage1_d = lane_words;
        stage2_d = stage1_q;
    end

    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            adc_lane_align_fsm #(
                .LANE_BITS    (LANE_BITS),
                .LANE_PATTERN (LANE_PATTERN),
                .MATCH_COUNT  (MATCH_COUNT),
                .SLIP_WAIT    (SLIP_WAIT),
                .MAX_TAPS     (MAX_TAPS)
            ) u_fsm (
                .lclk        (lclk),
                .rst         (rst),
                .start       (start),
                .lane_word   (stage1_q[gi*LANE_BITS +: LANE_BITS]),
                .bitslip     (bitslip[gi]),
                .delay_rst   (delay_rst[gi]),
                .delay_ce    (delay_ce[gi]),
                .delay_inc   (delay_inc[gi]),
                .lane_locked (lane_locked[gi]),
                .lane_fail   (lane_fail[gi]),
                .lane_busy   (lane_busy[gi]),
                .err_cnt     (err_cnt[gi*ERR_CNT_W +: ERR_CNT_W])
            );
        end
    endgenerate

    assign all_locked = &lane_locked;
    assign busy       = |lane_busy;
    assign adc_bits   = stage2_q;

endmodule

// File: tb/tb_adc_lane_aligner.sv
// Scoreboard bench for adc_lane_aligner: a behavioural SERDES model answers the
// bitslip/tap pulses, expected lock/fail outcomes are predicted from candidate order.
module tb_adc_lane_aligner;

    localparam int NL = 2;
    localparam int LB = 6;
    localparam int MC = 16;
    localparam int SW = 4;
    localparam int MT = 32;
    localparam logic [LB-1:0] PAT = 6'b111000;
    localparam int NEVER = 1000;

    logic                 lclk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [NL*LB-1:0]     lane_words = '0;
    logic [NL-1:0]        bitslip, delay_rst, delay_ce, delay_inc, lane_locked, lane_fail;
    logic                 all_locked, busy;
    logic [NL*LB-1:0]     adc_bits;
    logic [16*NL-1:0]     err_cnt;

    adc_lane_aligner dut (
        .lclk        (lclk),
        .rst         (rst),
        .start       (start),
        .lane_words  (lane_words),
        .bitslip     (bitslip),
        .delay_rst   (delay_rst),
        .delay_ce    (delay_ce),
        .delay_inc   (delay_inc),
        .lane_locked (lane_locked),
        .lane_fail   (lane_fail),
        .all_locked  (all_locked),
        .busy        (busy),
        .adc_bits    (adc_bits),
        .err_cnt     (err_cnt)
    );

    always #5 lclk = ~lclk;

    typedef struct {
        bit fail;
        int cycles;
        int slips;
        int taps;
    } exp_t;

    exp_t             exp_q[NL][$];
    logic [NL*LB-1:0] data_q[$];

    int vectors = 0;
    int miscompares = 0;

    // SERDES model: a lane shows the pattern only at its target tap, rotated by its skew.
    int tgt_tap[NL];
    int tgt_rot[NL];
    int m_slip[NL];
    int m_tap[NL];
    bit corrupt[NL];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [LB-1:0] rotl(input logic [LB-1:0] v, input int n);
        logic [LB-1:0] r = v;
        for (int i = 0; i < n; i++) r = {r[LB-2:0], r[LB-1]};
        return r;
    endfunction

    function automatic logic [LB-1:0] rotr(input logic [LB-1:0] v, input int n);
        logic [LB-1:0] r = v;
        for (int i = 0; i < n; i++) r = {r[0], r[LB-1:1]};
        return r;
    endfunction

    function automatic logic [LB-1:0] lane_model(input int l);
        logic [LB-1:0] w;
        if (m_tap[l] == tgt_tap[l]) begin
            w = rotr(rotl(PAT, tgt_rot[l]), m_slip[l]);
        end else begin
            w = LB'($urandom);
            if (w == PAT) w = w ^ LB'(1);
        end
        if (corrupt[l]) w = w ^ LB'(1);
        return w;
    endfunction

    // Candidates are tried tap-major, slip-minor; each costs one check, one pulse and SW settle cycles.
    function automatic exp_t predict(input int t, input int r);
        exp_t e;
        if (t >= MT) begin
            e.fail   = 1'b1;
            e.slips  = (LB - 1) * MT;
            e.taps   = MT - 1;
            e.cycles = 1 + SW + (LB * MT - 1) * (2 + SW) + 1;
        end else begin
            e.fail   = 1'b0;
            e.slips  = t * (LB - 1) + r;
            e.taps   = t;
            e.cycles = 1 + SW + (t * LB + r) * (2 + SW) + MC;
        end
        return e;
    endfunction

    // Word generator: drives every lane from the model and records the word for the data check.
    initial begin
        forever begin
            @(negedge lclk);
            if (!rst) begin
                for (int l = 0; l < NL; l++) lane_words[l*LB +: LB] = lane_model(l);
                data_q.push_back(lane_words);
            end
        end
    end

    // Monitor: updates the SERDES model from pulses and checks outputs against the scoreboard.
    int               cyc = 0;
    int               t0[NL];
    int               n_slip[NL];
    int               n_tap[NL];
    int               n_drst[NL];
    logic [NL-1:0]    prev_locked = '0;
    logic [NL-1:0]    prev_fail = '0;

    initial begin
        logic [NL*LB-1:0] dexp;
        exp_t             e;
        bit               pend;
        forever begin
            @(posedge lclk);
            #1;
            cyc++;
            if (rst) begin
                data_q.delete();
                prev_locked = '0;
                prev_fail   = '0;
                for (int l = 0; l < NL; l++) begin
                    m_slip[l] = 0;
                    m_tap[l]  = 0;
                end
            end else begin
                if (data_q.size() >= 2) begin
                    dexp = data_q.pop_front();
                    check("adc_bits", adc_bits, dexp);
                end
                if (start) check("delay_rst_at_start", delay_rst, {NL{1'b1}});
                for (int l = 0; l < NL; l++) begin
                    if (start) begin
                        t0[l] = cyc; n_slip[l] = 0; n_tap[l] = 0; n_drst[l] = 0;
                    end
                    if (delay_rst[l]) begin
                        n_drst[l]++; m_slip[l] = 0; m_tap[l] = 0;
                    end
                    if (bitslip[l]) begin
                        n_slip[l]++; m_slip[l]++;
                    end
                    if (delay_ce[l]) begin
                        n_tap[l]++; m_tap[l]++; m_slip[l] = 0;
                    end
                    if ((lane_locked[l] && !prev_locked[l]) || (lane_fail[l] && !prev_fail[l])) begin
                        if (exp_q[l].size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_done lane %0d: got locked=%0b fail=%0b, expected no event",
                                     l, lane_locked[l], lane_fail[l]);
                        end else begin
                            e = exp_q[l].pop_front();
                            $display("lane %0d done: locked=%0b after %0d cycles, %0d bitslips, %0d taps",
                                     l, lane_locked[l], cyc - t0[l], n_slip[l], n_tap[l]);
                            check($sformatf("lane%0d_fail_flag", l), lane_fail[l], e.fail);
                            check($sformatf("lane%0d_locked_flag", l), lane_locked[l], !e.fail);
                            check($sformatf("lane%0d_cycles", l), cyc - t0[l], e.cycles);
                            check($sformatf("lane%0d_bitslips", l), n_slip[l], e.slips);
                            check($sformatf("lane%0d_taps", l), n_tap[l], e.taps);
                            check($sformatf("lane%0d_delay_rst_count", l), n_drst[l], 1);
                        end
                    end
                end
                prev_locked = lane_locked;
                prev_fail   = lane_fail;
                pend = 1'b0;
                for (int l = 0; l < NL; l++) if (exp_q[l].size() != 0) pend = 1'b1;
                check("busy", busy, pend);
                check("all_locked", all_locked, &lane_locked);
                check("delay_inc", delay_inc, delay_ce);
            end
        end
    end

    task automatic launch(input int tap0, input int rot0, input int tap1, input int rot1);
        @(negedge lclk);
        tgt_tap[0] = tap0; tgt_rot[0] = rot0;
        tgt_tap[1] = tap1; tgt_rot[1] = rot1;
        for (int l = 0; l < NL; l++) begin
            exp_q[l].delete();
            exp_q[l].push_back(predict(tgt_tap[l], tgt_rot[l]));
        end
        start = 1'b1;
        @(negedge lclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < bound) begin
            @(posedge lclk);
            #2;
            n++;
        end
        check({"done_", name}, exp_q[0].size() + exp_q[1].size(), 0);
        for (int l = 0; l < NL; l++) exp_q[l].delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bitslip"}, bitslip, 0);
        check({tag, "_delay_rst"}, delay_rst, 0);
        check({tag, "_delay_ce"}, delay_ce, 0);
        check({tag, "_lane_locked"}, lane_locked, 0);
        check({tag, "_lane_fail"}, lane_fail, 0);
        check({tag, "_all_locked"}, all_locked, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_adc_bits"}, adc_bits, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        int n;
        int t0r, r0r, t1r, r1r;
        for (int l = 0; l < NL; l++) begin
            tgt_tap[l] = 0; tgt_rot[l] = 0; corrupt[l] = 1'b0;
        end
        repeat (3) @(posedge lclk);
        #2;
        check_all_zero("reset");
        #1 rst = 1'b0;
        repeat (2) @(posedge lclk);
        #2;
        check("idle_busy", busy, 0);

        // Lane 0 pre-aligned, lane 1 skewed by two bits.
        launch(0, 0, 0, 2);
        wait_done(200, "skew2");

        // Lane 0 needs three tap steps and four slips.
        launch(3, 4, 1, 1);
        wait_done(400, "tap3");

        // Randomized skews and tap targets.
        for (int k = 0; k < 3; k++) begin
            t0r = $urandom_range(0, 4); r0r = $urandom_range(0, LB - 1);
            t1r = $urandom_range(0, 4); r1r = $urandom_range(0, LB - 1);
            launch(t0r, r0r, t1r, r1r);
            wait_done(400, $sformatf("rand%0d", k));
        end

        // Lane 1 never matches: all slip/tap combinations, then lane_fail.
        launch($urandom_range(0, 2), $urandom_range(0, LB - 1), NEVER, 0);
        wait_done(1400, "never");
        check("fail_lane1", lane_fail, 2'b10);

        // Restart while lane 1 sits in its settle window after a bitslip.
        launch(0, 0, 3, 4);
        n = 0;
        while (!(lane_locked[0] && bitslip[1]) && n < 400) begin
            @(posedge lclk);
            #2;
            n++;
        end
        check("restart_window_found", n < 400, 1);
        @(posedge lclk);
        launch(0, 0, 3, 4);
        wait_done(400, "restart");

        // Corrupt three lane-0 words after lock.
        @(posedge lclk);
        #2;
        corrupt[0] = 1'b1;
        repeat (3) @(posedge lclk);
        #2;
        corrupt[0] = 1'b0;
        repeat (6) @(posedge lclk);
        #2;
`ifdef ADC_ALIGN_ERRCNT_EN
        check("err_cnt_lane0", err_cnt[15:0], 3);
`else
        check("err_cnt_lane0", err_cnt[15:0], 0);
`endif
        check("err_cnt_lane1", err_cnt[31:16], 0);
        // The corrupted words were ignored by the locked lanes.
        check("locked_after_corrupt", lane_locked, 2'b11);

        // Reset during a bitslip pulse, after lane 0 has locked.
        launch(0, 0, 2, 3);
        n = 0;
        while (!(lane_locked[0] && bitslip[1]) && n < 400) begin
            @(posedge lclk);
            #2;
            n++;
        end
        check("rst_window_found", n < 400, 1);
        check("err_cnt_cleared_by_start", err_cnt, 0);
        rst = 1'b1;
        for (int l = 0; l < NL; l++) exp_q[l].delete();
        #1;
        check_all_zero("async_rst");
        repeat (2) @(posedge lclk);
        #3 rst = 1'b0;
        repeat (3) @(posedge lclk);
        #2;
        check("post_rst_busy", busy, 0);
        check("post_rst_locked", lane_locked, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_lane_aligner.md
Name: adc_lane_aligner

Overview:
- Parametrised N-lane word-alignment controller for deserialized ADC data.
- Sits between the per-lane ADC SERDES instances and sample consumers; runs in the lclk domain.
- Checks each lane's parallel word against a training pattern.
- Drives per-lane bitslip and input-delay tap controls until every lane locks, then presents the assembled sample word with fixed latency.

Parameters:
- N_LANES, 2, number of serial lanes per ADC channel
- LANE_BITS, 6, deserialized bits per lane per lclk cycle
- LANE_PATTERN, 6'b111000, expected per-lane training word (LANE_BITS wide)
- MATCH_COUNT, 16, consecutive matches required to declare lock (>=1)
- SLIP_WAIT, 4, settle cycles after any bitslip/tap pulse (>=1)
- MAX_TAPS, 32, delay taps available per lane

Ports:
- lclk, in, 1, sole clock
- rst, in, 1, asynchronous active-high reset
- start, in, 1, single-cycle pulse; (re)starts alignment on all lanes
- lane_words, in, N_LANES*LANE_BITS, SERDES outputs, lane 0 in LSBs
- bitslip, out, N_LANES, one-cycle bitslip pulse per lane
- delay_rst, out, N_LANES, one-cycle delay-tap reset pulse per lane
- delay_ce, out, N_LANES, one-cycle tap-step enable per lane
- delay_inc, out, N_LANES, tap direction; always 1 when delay_ce=1
- lane_locked, out, N_LANES, lane aligned
- lane_fail, out, N_LANES, lane exhausted all slip/tap combinations
- all_locked, out, 1, AND of lane_locked
- busy, out, 1, any lane in an active alignment state
- adc_bits, out, N_LANES*LANE_BITS, assembled sample word
- err_cnt, out, 16*N_LANES, post-lock mismatch counters (see Optional Feature)

Behaviour:
- Reset: all outputs 0. Every lane FSM goes to IDLE; counters clear.
- Input lane_words is registered once (stage 1). Comparison uses stage 1. adc_bits = stage 2. Data latency is 2 lclk, independent of lock state.
- Per-lane FSM states: IDLE, INIT, CHECK, SLIP, TAP, WAIT, LOCKED, FAIL.
- IDLE/LOCKED/FAIL + start -> INIT. INIT pulses delay_rst for 1 cycle, clears slip_cnt, tap_cnt and match_cnt, then goes to WAIT.
- WAIT counts SLIP_WAIT cycles, then goes to CHECK. Compare results are ignored during WAIT.
- CHECK, match: match_cnt++. When match_cnt reaches MATCH_COUNT -> LOCKED.
- CHECK, mismatch: match_cnt clears.
  - If slip_cnt < LANE_BITS-1 -> SLIP.
  - Else if tap_cnt < MAX_TAPS-1 -> TAP.
  - Else -> FAIL.
- SLIP: bitslip=1 for exactly 1 cycle, slip_cnt++, -> WAIT.
- TAP: delay_ce=delay_inc=1 for 1 cycle, tap_cnt++, slip_cnt=0, -> WAIT.
- Worst case: LANE_BITS*MAX_TAPS candidate alignments are tried before FAIL.
- lane_locked=1 only in LOCKED. lane_fail=1 only in FAIL. busy=1 in INIT/CHECK/SLIP/TAP/WAIT on any lane.
- start while busy: all lanes abort and restart at INIT on the next cycle, regardless of state. Any pulse in flight completes its single cycle first.
- Lanes run independently. Simultaneous lock or fail across lanes is permitted.
- all_locked updates the same cycle as the last lane_locked.
- LOCKED holds with no further checks; alignment resumes only on start.
- rst asserted mid-alignment: outputs drop to 0 asynchronously. No pulse may extend past reset.

Optional Feature:
- Macro ADC_ALIGN_ERRCNT_EN.
- Defined: in LOCKED, each stage-1 mismatch against LANE_PATTERN increments that lane's 16-bit err_cnt. The counter saturates at 16'hFFFF and clears on start or rst.
- Not defined: err_cnt is tied to 0 and no counter logic is synthesised. The port is still present.

Decomposition:
- Shared package adc_align_pkg holds:
  - lane FSM state enum (3-bit encoding)
  - default LANE_PATTERN, MATCH_COUNT, SLIP_WAIT and MAX_TAPS constants
  - ERR_CNT_W=16
- One sub-module, adc_lane_align_fsm, instantiated N_LANES times in a generate loop. Each instance owns the per-lane FSM, its counters and err_cnt.
- The top level owns input staging, output assembly and all_locked/busy reduction.

Test Plan:
- Lane 0 pre-aligned (111000), lane 1 rotated by 2 (100011); pulse start.
  - Lane 0 locks after 1+4+16 cycles with no bitslip.
  - Lane 1 gets exactly 2 bitslip pulses before locking.
  - all_locked rises when lane 1 locks.
- Model needing a tap step (pattern valid only at tap 3, slip 4).
  - Exactly 3 delay_ce pulses; slip_cnt resets after each tap.
  - Lock at slip 4; delay_rst pulses once at start.
- Lane never matches.
  - 5 bitslips per tap, 31 taps, then lane_fail=1, lane_locked=0, busy=0.
- Pulse start again while lane 1 is mid-WAIT.
  - Both lanes re-enter INIT on the next cycle; delay_rst pulses on both lanes.
- Assert rst during a bitslip pulse: bitslip, busy and lane_locked go to 0 immediately; adc_bits=0.
- With ADC_ALIGN_ERRCNT_EN: after lock, inject 3 corrupted words on lane 0 -> err_cnt[15:0]=3, lane 1 count=0. Without the macro, err_cnt stays 0.
